// File: rtl/adder_link_client.sv
// adder_link_client: host-side initiator for the UART decimal-adder service.
// Sends "<00>aaa-bbb<LF>" as ASCII digits, then parses the "SUM:ddd ... COUT:d<LF>" report.
module adder_link_client #(
  parameter int                 TO_BITS = 24,
  parameter logic [TO_BITS-1:0] TIMEOUT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  output logic       ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic [9:0] result_sum,
  output logic       result_cout,
  output logic       result_valid,
  output logic [1:0] result_err
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD      = 4'd1;
  localparam logic [3:0] ST_SEND      = 4'd2;
  localparam logic [3:0] ST_WAIT_TX   = 4'd3;
  localparam logic [3:0] ST_HUNT_SUM  = 4'd4;
  localparam logic [3:0] ST_SUM_DIG   = 4'd5;
  localparam logic [3:0] ST_HUNT_COUT = 4'd6;
  localparam logic [3:0] ST_COUT_DIG  = 4'd7;
  localparam logic [3:0] ST_EOL       = 4'd8;
  localparam logic [3:0] ST_DONE      = 4'd9;
  localparam logic [3:0] ST_FAIL      = 4'd10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_FORMAT  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [TO_BITS-1:0] TO_ZERO = {TO_BITS{1'b0}};
  localparam logic [TO_BITS-1:0] TO_ONE  = {{(TO_BITS-1){1'b0}}, 1'b1};
  localparam logic [TO_BITS-1:0] TO_LAST = TIMEOUT - TO_ONE;

  function automatic logic [3:0] hundreds(input logic [7:0] v);
    return 4'(v / 8'd100);
  endfunction

  function automatic logic [3:0] tens(input logic [7:0] v);
    return 4'((v % 8'd100) / 8'd10);
  endfunction

  function automatic logic [3:0] units(input logic [7:0] v);
    return 4'(v % 8'd10);
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic [7:0] sum_kw(input logic [2:0] i);
    logic [7:0] c;
    case (i)
      3'd0:    c = 8'h53;
      3'd1:    c = 8'h55;
      3'd2:    c = 8'h4D;
      3'd3:    c = 8'h3A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] cout_kw(input logic [2:0] i);
    logic [7:0] c;
    case (i)
      3'd0:    c = 8'h43;
      3'd1:    c = 8'h4F;
      3'd2:    c = 8'h55;
      3'd3:    c = 8'h54;
      3'd4:    c = 8'h3A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [3:0]         state_r, state_nxt_s;
  logic [7:0]         opa_r, opb_r;
  logic [3:0]         ah_r, at_r, au_r, bh_r, bt_r, bu_r;
  logic [3:0]         idx_r, idx_nxt_s;
  logic               gap_r, gap_nxt_s;
  logic [2:0]         match_r, match_nxt_s;
  logic [1:0]         dcnt_r, dcnt_nxt_s;
  logic [9:0]         sum_r, sum_nxt_s, sum_x10_s;
  logic               cout_r, cout_nxt_s;
  logic [1:0]         err_r, err_nxt_s;
  logic [TO_BITS-1:0] to_cnt_r, to_nxt_s;
  logic [7:0]         frame_byte_s;
  logic               ready_r, tx_start_r, valid_r;
  logic [7:0]         tx_data_r;

  assign ready        = ready_r;
  assign tx_start     = tx_start_r;
  assign tx_data      = tx_data_r;
  assign result_sum   = sum_r;
  assign result_cout  = cout_r;
  assign result_valid = valid_r;
  assign result_err   = err_r;

  assign sum_x10_s = sum_r * 10'd10;

  // Request-frame byte for the index the next SEND will transmit.
  always_comb begin
    frame_byte_s = 8'h00;
    case (idx_nxt_s)
      4'd0:    frame_byte_s = 8'h00;
      4'd1:    frame_byte_s = ascii_digit(ah_r);
      4'd2:    frame_byte_s = ascii_digit(at_r);
      4'd3:    frame_byte_s = ascii_digit(au_r);
      4'd4:    frame_byte_s = 8'h2D;
      4'd5:    frame_byte_s = ascii_digit(bh_r);
      4'd6:    frame_byte_s = ascii_digit(bt_r);
      4'd7:    frame_byte_s = ascii_digit(bu_r);
      4'd8:    frame_byte_s = 8'h0A;
      default: frame_byte_s = 8'h00;
    endcase
  end

  // Next-state and datapath updates for the request/response sequence.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    gap_nxt_s   = 1'b0;
    match_nxt_s = match_r;
    dcnt_nxt_s  = dcnt_r;
    sum_nxt_s   = sum_r;
    cout_nxt_s  = cout_r;
    err_nxt_s   = err_r;
    to_nxt_s    = to_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_LOAD;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        idx_nxt_s   = 4'd0;
        sum_nxt_s   = 10'd0;
        cout_nxt_s  = 1'b0;
        err_nxt_s   = ERR_OK;
        state_nxt_s = ST_SEND;
      end
      ST_SEND: state_nxt_s = ST_WAIT_TX;
      ST_WAIT_TX: begin
        // One idle cycle after tx_done lets the Transmitter settle before the next strobe.
        if (gap_r) begin
          state_nxt_s = ST_SEND;
        end else if (tx_done) begin
          idx_nxt_s = idx_r + 4'd1;
          if (idx_r < 4'd8) begin
            gap_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_HUNT_SUM;
            match_nxt_s = 3'd0;
            to_nxt_s    = TO_ZERO;
          end
        end else begin
          state_nxt_s = ST_WAIT_TX;
        end
      end
      ST_HUNT_SUM, ST_SUM_DIG, ST_HUNT_COUT, ST_COUT_DIG, ST_EOL: begin
        if (rx_done) begin
          to_nxt_s = TO_ZERO;
          case (state_r)
            ST_HUNT_SUM: begin
              if (rx_data == sum_kw(match_r)) begin
                if (match_r == 3'd3) begin
                  state_nxt_s = ST_SUM_DIG;
                  dcnt_nxt_s  = 2'd0;
                  match_nxt_s = 3'd0;
                end else begin
                  match_nxt_s = match_r + 3'd1;
                end
              end else if (rx_data == 8'h53) begin
                match_nxt_s = 3'd1;
              end else begin
                match_nxt_s = 3'd0;
              end
            end
            ST_SUM_DIG: begin
              if (is_digit(rx_data)) begin
                sum_nxt_s = sum_x10_s + {6'd0, rx_data[3:0]};
                if (dcnt_r == 2'd2) begin
                  state_nxt_s = ST_HUNT_COUT;
                  match_nxt_s = 3'd0;
                end else begin
                  dcnt_nxt_s = dcnt_r + 2'd1;
                end
              end else begin
                err_nxt_s   = ERR_FORMAT;
                state_nxt_s = ST_FAIL;
              end
            end
            ST_HUNT_COUT: begin
              if (rx_data == cout_kw(match_r)) begin
                if (match_r == 3'd4) begin
                  state_nxt_s = ST_COUT_DIG;
                  match_nxt_s = 3'd0;
                end else begin
                  match_nxt_s = match_r + 3'd1;
                end
              end else if (rx_data == 8'h43) begin
                match_nxt_s = 3'd1;
              end else begin
                match_nxt_s = 3'd0;
              end
            end
            ST_COUT_DIG: begin
              case (rx_data)
                8'h30: begin
                  cout_nxt_s  = 1'b0;
                  state_nxt_s = ST_EOL;
                end
                8'h31: begin
                  cout_nxt_s  = 1'b1;
                  state_nxt_s = ST_EOL;
                end
                default: begin
                  err_nxt_s   = ERR_FORMAT;
                  state_nxt_s = ST_FAIL;
                end
              endcase
            end
            default: begin
              if (rx_data == 8'h0A) begin
                err_nxt_s   = ERR_OK;
                state_nxt_s = ST_DONE;
              end else begin
                state_nxt_s = ST_EOL;
              end
            end
          endcase
        end else if (to_cnt_r == TO_LAST) begin
          to_nxt_s    = to_cnt_r + TO_ONE;
          err_nxt_s   = ERR_TIMEOUT;
          state_nxt_s = ST_FAIL;
        end else begin
          to_nxt_s = to_cnt_r + TO_ONE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      ST_FAIL: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, operand/digit latches, parse state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      opa_r      <= 8'd0;
      opb_r      <= 8'd0;
      ah_r       <= 4'd0;
      at_r       <= 4'd0;
      au_r       <= 4'd0;
      bh_r       <= 4'd0;
      bt_r       <= 4'd0;
      bu_r       <= 4'd0;
      idx_r      <= 4'd0;
      gap_r      <= 1'b0;
      match_r    <= 3'd0;
      dcnt_r     <= 2'd0;
      sum_r      <= 10'd0;
      cout_r     <= 1'b0;
      err_r      <= ERR_OK;
      to_cnt_r   <= TO_ZERO;
      ready_r    <= 1'b1;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
      valid_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      idx_r    <= idx_nxt_s;
      gap_r    <= gap_nxt_s;
      match_r  <= match_nxt_s;
      dcnt_r   <= dcnt_nxt_s;
      sum_r    <= sum_nxt_s;
      cout_r   <= cout_nxt_s;
      err_r    <= err_nxt_s;
      to_cnt_r <= to_nxt_s;
      if ((state_r == ST_IDLE) && start) begin
        opa_r <= operand_a;
        opb_r <= operand_b;
      end
      if (state_r == ST_LOAD) begin
        ah_r <= hundreds(opa_r);
        at_r <= tens(opa_r);
        au_r <= units(opa_r);
        bh_r <= hundreds(opb_r);
        bt_r <= tens(opb_r);
        bu_r <= units(opb_r);
      end
      ready_r    <= (state_nxt_s == ST_IDLE);
      tx_start_r <= (state_nxt_s == ST_SEND);
      if (state_nxt_s == ST_SEND) begin
        tx_data_r <= frame_byte_s;
      end
      valid_r <= (state_nxt_s == ST_DONE) || (state_nxt_s == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_adder_link_client.sv
// tb_adder_link_client: directed bench playing the Transmitter and Receiver roles
// around adder_link_client, with a 100-cycle response timeout.
`timescale 1ns/1ps
module tb_adder_link_client;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [9:0] result_sum;
  logic       result_cout;
  logic       result_valid;
  logic [1:0] result_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_frame [9];

  adder_link_client #(.TO_BITS(24), .TIMEOUT(24'd100)) dut (
    .clk(clk), .reset(reset), .start(start),
    .operand_a(operand_a), .operand_b(operand_b), .ready(ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .rx_done(rx_done), .rx_data(rx_data),
    .result_sum(result_sum), .result_cout(result_cout),
    .result_valid(result_valid), .result_err(result_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; operand_a = 8'd0; operand_b = 8'd0;
    tx_done = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready, tx_start, tx_data, result_valid, result_err, result_sum, result_cout} !==
        {1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 10'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b tx_start=%b tx_data=%h valid=%b err=%b sum=%0d cout=%b, required 1 0 00 0 00 0 0",
               ready, tx_start, tx_data, result_valid, result_err, result_sum, result_cout);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready, tx_start, result_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b tx_start=%b valid=%b, required 1 0 0", ready, tx_start, result_valid);
    end
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait: ready=%b, required 1", ready);
    end
    operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; operand_a = 8'd0; operand_b = 8'd0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_drop: ready=%b, required 0", ready);
    end
  endtask

  // Checks each strobed byte, then answers it with a one-cycle tx_done.
  task automatic tx_frame(input int nbytes, input bit noise);
    int w;
    for (int i = 0; i < nbytes; i++) begin
      w = 0;
      while (tx_start !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      n_checks++;
      if (tx_start !== 1'b1 || w < 1 || (i == 0 && w != 1)) begin
        n_fail++;
        $display("FAIL tx_start_timing byte %0d: tx_start=%b after %0d cycles, required 1 after %s",
                 i, tx_start, w, (i == 0) ? "exactly 1" : "at least 1");
      end
      n_checks++;
      if (tx_data !== exp_frame[i]) begin
        n_fail++;
        $display("FAIL tx_byte %0d: tx_data=%h, required %h", i, tx_data, exp_frame[i]);
      end
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b0) begin
        n_fail++;
        $display("FAIL tx_start_pulse byte %0d: tx_start=%b, required 0", i, tx_start);
      end
      if (noise && i == 3) begin
        start = 1'b1; operand_a = 8'd9; operand_b = 8'd9;
        rx_done = 1'b1; rx_data = 8'h0A;
        @(negedge clk);
        start = 1'b0; rx_done = 1'b0;
      end else begin
        @(negedge clk);
      end
      n_checks++;
      if (tx_data !== exp_frame[i]) begin
        n_fail++;
        $display("FAIL tx_data_stable byte %0d: tx_data=%h, required %h", i, tx_data, exp_frame[i]);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_data = s[i];
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      if (i != s.len() - 1) @(negedge clk);
    end
  endtask

  task automatic test_basic();
    exp_frame = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h2D, 8'h30, 8'h34, 8'h35, 8'h0A};
    do_start(8'd123, 8'd45);
    tx_frame(9, 1'b0);
    @(negedge clk);
    feed(" NUMBER1:123 NUMBER2:045 SUM:168 COUT:0\n");
    n_checks++;
    if ({result_valid, result_err, result_sum, result_cout, ready} !== {1'b1, 2'b00, 10'd168, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: valid=%b err=%b sum=%0d cout=%b ready=%b, required 1 00 168 0 0",
               result_valid, result_err, result_sum, result_cout, ready);
    end
    @(negedge clk);
    n_checks++;
    if ({result_valid, ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_after: valid=%b ready=%b, required 0 1", result_valid, ready);
    end
  endtask

  task automatic test_carry_restart();
    exp_frame = '{8'h00, 8'h32, 8'h35, 8'h35, 8'h2D, 8'h32, 8'h35, 8'h35, 8'h0A};
    do_start(8'd255, 8'd255);
    tx_frame(9, 1'b0);
    @(negedge clk);
    feed(" NUMBER1:255 NUMBER2:255 SU SSUM:254 CCOUT:1\n");
    n_checks++;
    if ({result_valid, result_err, result_sum, result_cout} !== {1'b1, 2'b00, 10'd254, 1'b1}) begin
      n_fail++;
      $display("FAIL carry_result: valid=%b err=%b sum=%0d cout=%b, required 1 00 254 1",
               result_valid, result_err, result_sum, result_cout);
    end
    @(negedge clk);
    n_checks++;
    if ({result_valid, ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL carry_after: valid=%b ready=%b, required 0 1", result_valid, ready);
    end
  endtask

  task automatic test_format_error();
    exp_frame = '{8'h00, 8'h31, 8'h30, 8'h30, 8'h2D, 8'h30, 8'h32, 8'h34, 8'h0A};
    do_start(8'd100, 8'd24);
    tx_frame(9, 1'b0);
    @(negedge clk);
    feed(" NUMBER1:100 NUMBER2:024 SUM:1x");
    n_checks++;
    if ({result_valid, result_err} !== {1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL format_err: valid=%b err=%b, required 1 01", result_valid, result_err);
    end
    @(negedge clk);
    n_checks++;
    if ({result_valid, ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL format_after: valid=%b ready=%b, required 0 1", result_valid, ready);
    end
  endtask

  task automatic test_timeout();
    exp_frame = '{8'h00, 8'h30, 8'h30, 8'h37, 8'h2D, 8'h30, 8'h30, 8'h30, 8'h0A};
    do_start(8'd7, 8'd0);
    tx_frame(9, 1'b0);
    repeat (99) @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: valid=%b at cycle 99, required 0", result_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({result_valid, result_err} !== {1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL timeout_exact: valid=%b err=%b at cycle 100, required 1 10", result_valid, result_err);
    end
    @(negedge clk);
    n_checks++;
    if ({result_valid, ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_after: valid=%b ready=%b, required 0 1", result_valid, ready);
    end
    exp_frame = '{8'h00, 8'h32, 8'h35, 8'h35, 8'h2D, 8'h30, 8'h30, 8'h31, 8'h0A};
    do_start(8'd255, 8'd1);
    tx_frame(9, 1'b0);
    repeat (99) @(negedge clk);
    rx_data = 8'h58;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_restart_100: valid=%b, required 0", result_valid);
    end
    repeat (99) @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_restart_199: valid=%b, required 0", result_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({result_valid, result_err} !== {1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL timeout_restart_200: valid=%b err=%b, required 1 10", result_valid, result_err);
    end
  endtask

  task automatic test_busy_and_abort();
    exp_frame = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h2D, 8'h30, 8'h34, 8'h35, 8'h0A};
    do_start(8'd123, 8'd45);
    tx_frame(9, 1'b1);
    @(negedge clk);
    feed(" NUMBER1:123 NUMBER2:045 SUM:168 COUT:0\n");
    n_checks++;
    if ({result_valid, result_err, result_sum, result_cout} !== {1'b1, 2'b00, 10'd168, 1'b0}) begin
      n_fail++;
      $display("FAIL busy_result: valid=%b err=%b sum=%0d cout=%b, required 1 00 168 0",
               result_valid, result_err, result_sum, result_cout);
    end
    exp_frame = '{8'h00, 8'h32, 8'h30, 8'h30, 8'h2D, 8'h30, 8'h39, 8'h39, 8'h0A};
    do_start(8'd200, 8'd99);
    tx_frame(4, 1'b0);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({tx_start, ready, result_valid, tx_data} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_reset: tx_start=%b ready=%b valid=%b tx_data=%h, required 0 1 0 00",
               tx_start, ready, result_valid, tx_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_start, result_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_hold %0d: tx_start=%b valid=%b, required 0 0", k, tx_start, result_valid);
      end
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_start, result_valid, ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_release: tx_start=%b valid=%b ready=%b, required 0 0 1", tx_start, result_valid, ready);
    end
    exp_frame = '{8'h00, 8'h30, 8'h36, 8'h36, 8'h2D, 8'h30, 8'h37, 8'h37, 8'h0A};
    do_start(8'd66, 8'd77);
    tx_frame(9, 1'b0);
    @(negedge clk);
    feed(" NUMBER1:066 NUMBER2:077 SUM:143 COUT:0\n");
    n_checks++;
    if ({result_valid, result_err, result_sum, result_cout} !== {1'b1, 2'b00, 10'd143, 1'b0}) begin
      n_fail++;
      $display("FAIL after_abort_result: valid=%b err=%b sum=%0d cout=%b, required 1 00 143 0",
               result_valid, result_err, result_sum, result_cout);
    end
    @(negedge clk);
    n_checks++;
    if ({result_valid, ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_abort_idle: valid=%b ready=%b, required 0 1", result_valid, ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_restart();
    test_format_error();
    test_timeout();
    test_busy_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_link_client.md
# adder_link_client

Host-side initiator for the UART decimal-adder service. Takes two 8-bit operands and encodes them as an ASCII request frame, issued byte-by-byte to a `Transmitter` instance. It then parses the service's ASCII report arriving from a `Receiver` instance and returns the reported sum and carry with error/timeout status. It sits between a test/control master and the byte-level UART units, on the far end of the link from the adder service.

## Interface
Parameters:
- `TO_BITS`, 24: width of the response timeout counter.
- `TIMEOUT`, 24'd10_000_000: clock cycles allowed between received bytes while a response is pending.

Ports:
- `clk` input 1: system clock; all logic on posedge.
- `reset` input 1: asynchronous, active-low reset; 0 = reset.
- `start` input 1: request strobe; sampled only when `ready`=1.
- `operand_a` input 8: number1, 0..255.
- `operand_b` input 8: number2, 0..255.
- `ready` output 1: idle, accepting `start`.
- `tx_start` output 1: one-cycle byte-send strobe to Transmitter.
- `tx_data` output 8: byte to send.
- `tx_done` input 1: one-cycle byte-sent pulse from Transmitter.
- `rx_done` input 1: one-cycle byte-received pulse from Receiver.
- `rx_data` input 8: received byte, valid when `rx_done`=1.
- `result_sum` output 10: parsed SUM value, 0..999.
- `result_cout` output 1: parsed COUT digit.
- `result_valid` output 1: one-cycle completion pulse.
- `result_err` output 2: status qualified by `result_valid`:
  - 00: ok
  - 01: format error
  - 10: timeout

## Operation
- Request frame, 9 bytes, in order:
  - 0x00 (index sync)
  - hundreds, tens and units of `operand_a`
  - 0x2D (`-`)
  - hundreds, tens and units of `operand_b`
  - 0x0A (LF)
- Digits are ASCII `0`..`9` (0x30+d), always three digits with leading zeros. Example: 7 → `007`.
- Digit split: h = v/100, t = (v%100)/10, u = v%10. Operands are latched at start acceptance and are don't-care afterwards.
- States:
  - IDLE: `ready`=1. `start` → LOAD.
  - LOAD: register the six digits, clear the byte index → SEND.
  - SEND: drive `tx_start`=1 for one cycle with `tx_data`=frame[idx] → WAIT_TX.
  - WAIT_TX: on `tx_done`, idx+1. Go to SEND if idx<8, else HUNT_SUM. `tx_data` stays stable until `tx_done`.
  - HUNT_SUM: match the keyword `SUM:`. On a mismatching byte, match index = 1 if the byte is `S`, else 0. Full match → SUM_DIG.
  - SUM_DIG: accept 3 bytes. sum = sum*10 + (byte-0x30). A non-digit → FAIL(01).
  - HUNT_COUT: match `COUT:` with the same restart rule (restart char `C`) → COUT_DIG.
  - COUT_DIG: `0` → cout=0, `1` → cout=1, other → FAIL(01). Then → EOL.
  - EOL: skip bytes until 0x0A → DONE(00).
  - DONE/FAIL: `result_valid`=1 for one cycle with `result_err`, then → IDLE.
- `rx_done` pulses during LOAD/SEND/WAIT_TX are ignored. `start` while `ready`=0 is ignored.
- Timeout counter:
  - Cleared on entry to HUNT_SUM and on every `rx_done`.
  - Increments each cycle in HUNT_SUM..EOL.
  - Reaching `TIMEOUT` → FAIL(10).
  - `rx_done` in the same cycle as the limit wins: the byte is consumed and the counter clears.
- On FAIL: `result_sum` and `result_cout` hold their partial values; they are meaningful only when `result_err`=00.

## Timing
- Reset (`reset`=0, asynchronous) forces:
  - state IDLE, `ready`=1
  - `tx_start`=0, `tx_data`=0x00
  - `result_valid`=0, `result_err`=00, `result_sum`=0, `result_cout`=0
  - timeout counter 0
- Reset mid-frame aborts with no `result_valid`. Release is sampled at the next posedge.
- `start` accepted at edge T:
  - `ready`=0 from T+1 (LOAD).
  - First `tx_start` at T+2.
- `tx_done` at cycle D: next `tx_start` at D+2, at the earliest.
- Final LF `rx_done` at cycle R: `result_valid`=1 at R+1 and `ready`=1 at R+2.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- `operand_a`=123, `operand_b`=45, start → tx bytes 00 31 32 33 2D 30 34 35 0A, one `tx_start` per `tx_done`. Then feed " NUMBER1:123 NUMBER2:045 SUM:168 COUT:0\n" → `result_valid` with `result_sum`=168, `result_cout`=0, err=00.
- 255+255, response "...SUM:254 COUT:1\n" → `result_sum`=254, `result_cout`=1, err=00. Also feed "SSUM:" inside the prefix; the match must still succeed.
- Response "...SUM:1x4 ..." → `result_valid` with err=01 immediately after `x`, then `ready`=1.
- `TIMEOUT`=100: no response after the frame → err=10 exactly 100 cycles after entering HUNT_SUM. A byte arriving at cycle 99 restarts the count.
- Pulse `start` while `ready`=0 → no effect on frame or results. Drop `reset` after the 4th `tx_done` → `tx_start`=0, `ready`=1 immediately, no `result_valid`. A new request then completes normally.
